// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Subtract is A + ~B + 1, with the +1 entering through the preset carry.
module serial_addsub #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   load;
   logic   step;
   logic   finish;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    count;
   logic             c;
   logic             fa_s;
   logic             fa_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath strobes
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == LAST) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Status flags track the state one-for-one but come straight from flops
   always_ff @(posedge clk) begin
      if (rst) begin
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         ready <= (state_nxt == IDLE);
         busy  <= (state_nxt == RUN);
         done  <= (state_nxt == DONE);
      end
   end

   // Single full-adder cell
   always_comb begin
      fa_s = sa[0] ^ sb[0] ^ c;
      fa_c = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa        <= '0;
         sb        <= '0;
         sr        <= '0;
         count     <= '0;
         c         <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (load) begin
         sa    <= a;
         sb    <= sub ? ~b : b;
         c     <= sub;
         count <= '0;
      end else if (step) begin
         sa    <= {1'b0, sa[WIDTH-1:1]};
         sb    <= {1'b0, sb[WIDTH-1:1]};
         sr    <= {fa_s, sr[WIDTH-1:1]};
         c     <= fa_c;
         count <= count + CW'(1);
         // On the MSB step, c is the carry into the MSB
         if (finish) begin
            result    <= {fa_s, sr[WIDTH-1:1]};
            carry_out <= fa_c;
            overflow  <= c ^ fa_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=4: arithmetic cases, handshake
// rules, reset abort, result hold and an exhaustive operand sweep.
module tb_serial_addsub;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   int vectors;
   int miscompares;

   serial_addsub #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {overflow, carry_out, result} from plain integer arithmetic
   function automatic logic [5:0] ref_op(input logic [3:0] x, input logic [3:0] y,
                                         input logic s);
      logic [3:0] yy;
      logic [4:0] full;
      logic       ovf;
      yy   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + 5'(s);
      ovf  = (x[3] == yy[3]) && (full[3] != x[3]);
      return {ovf, full[4], full[3:0]};
   endfunction

   // Launch one operation; returns on the first negedge with done=1 (or timeout).
   // lat = number of active edges after the start edge before done was seen.
   task automatic do_op(input logic [3:0] xa, input logic [3:0] xb, input logic xs,
                        output int lat);
      @(negedge clk);
      a = xa; b = xb; sub = xs; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({ready, busy, done} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_status: got %b expected 100", {ready, busy, done});
      end
      vectors++;
      if ({result, carry_out, overflow} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_data: got %b expected 000000", {result, carry_out, overflow});
      end
      // start together with rst is dropped
      start = 1'b1; a = 4'd5; b = 4'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if ({ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_wins: got %b expected 10", {ready, busy});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add_overflow;
      @(negedge clk);
      a = 4'd5; b = 4'd3; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if ({ready, busy, done} !== 3'b010) begin
         miscompares++;
         $display("FAIL run_status: got %b expected 010", {ready, busy, done});
      end
      for (int k = 1; k < WIDTH; k++) begin
         @(negedge clk);
         vectors++;
         if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL early_done: edge %0d got %b expected 0", k, done);
         end
      end
      @(negedge clk);
      vectors++;
      if ({done, busy, result, carry_out, overflow} !== {1'b1, 1'b0, 4'd8, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL add_5_3: got done=%b busy=%b res=%h c=%b v=%b expected 1 0 8 0 1",
                  done, busy, result, carry_out, overflow);
      end
      @(negedge clk);
      vectors++;
      if ({done, ready, result} !== {1'b0, 1'b1, 4'd8}) begin
         miscompares++;
         $display("FAIL done_pulse: got done=%b ready=%b res=%h expected 0 1 8",
                  done, ready, result);
      end
   endtask

   task automatic test_sub;
      int lat;
      do_op(4'd7, 4'd2, 1'b1, lat);
      vectors++;
      if (lat !== 4 || {result, carry_out, overflow} !== {4'd5, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL sub_7_2: got lat=%0d res=%h c=%b v=%b expected 4 5 1 0",
                  lat, result, carry_out, overflow);
      end
      do_op(4'd2, 4'd7, 1'b1, lat);
      vectors++;
      if (lat !== 4 || {result, carry_out, overflow} !== {4'hB, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL sub_2_7: got lat=%0d res=%h c=%b v=%b expected 4 b 0 0",
                  lat, result, carry_out, overflow);
      end
   endtask

   task automatic test_wrap;
      int lat;
      do_op(4'd15, 4'd1, 1'b0, lat);
      vectors++;
      if (lat !== 4 || {result, carry_out, overflow} !== {4'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL add_15_1: got lat=%0d res=%h c=%b v=%b expected 4 0 1 0",
                  lat, result, carry_out, overflow);
      end
      do_op(4'd8, 4'd1, 1'b1, lat);
      vectors++;
      if (lat !== 4 || {result, carry_out, overflow} !== {4'd7, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL sub_8_1: got lat=%0d res=%h c=%b v=%b expected 4 7 1 1",
                  lat, result, carry_out, overflow);
      end
   endtask

   task automatic test_ignore_start;
      int n;
      bit extra;
      @(negedge clk);
      a = 4'd5; b = 4'd3; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'd1; b = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if ({done, result, carry_out, overflow} !== {1'b1, 4'd8, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL ignore_start: got done=%b res=%h c=%b v=%b expected 1 8 0 1",
                  done, result, carry_out, overflow);
      end
      extra = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done || !ready) extra = 1'b1;
      end
      vectors++;
      if (extra !== 1'b0) begin
         miscompares++;
         $display("FAIL queued_op: got %b expected 0", extra);
      end
   endtask

   task automatic test_toggle_inputs;
      int n;
      @(negedge clk);
      a = 4'd7; b = 4'd2; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         a = 4'($urandom); b = 4'($urandom); sub = ~sub;
         @(negedge clk);
         n++;
      end
      vectors++;
      if ({done, result, carry_out, overflow} !== {1'b1, 4'd5, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL toggle_inputs: got done=%b res=%h c=%b v=%b expected 1 5 1 0",
                  done, result, carry_out, overflow);
      end
      a = '0; b = '0; sub = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int first;
      int second;
      int i;
      first = -1; second = -1;
      @(negedge clk);
      a = 4'd15; b = 4'd1; sub = 1'b0; start = 1'b1;
      i = 0;
      while (second < 0 && i < 30) begin
         @(negedge clk);
         i++;
         if (done) begin
            vectors++;
            if ({result, carry_out} !== {4'd0, 1'b1}) begin
               miscompares++;
               $display("FAIL b2b_result: got res=%h c=%b expected 0 1", result, carry_out);
            end
            if (first < 0) first = i;
            else second = i;
         end
      end
      start = 1'b0;
      vectors++;
      if (first !== 5 || second !== 11) begin
         miscompares++;
         $display("FAIL b2b_spacing: got %0d,%0d expected 5,11", first, second);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int lat;
      bit seen;
      @(negedge clk);
      a = 4'd5; b = 4'd3; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({ready, busy, done, result, carry_out, overflow} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid: got rdy=%b busy=%b done=%b res=%h c=%b v=%b expected 1 0 0 0 0 0",
                  ready, busy, done, result, carry_out, overflow);
      end
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL aborted_done: got %b expected 0", seen);
      end
      do_op(4'd1, 4'd1, 1'b0, lat);
      vectors++;
      if (lat !== 4 || {result, carry_out, overflow} !== {4'd2, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL after_reset: got lat=%0d res=%h c=%b v=%b expected 4 2 0 0",
                  lat, result, carry_out, overflow);
      end
   endtask

   task automatic test_hold;
      int lat;
      do_op(4'd2, 4'd7, 1'b1, lat);
      a = 4'd9; b = 4'd9;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         vectors++;
         if ({result, carry_out, overflow, ready, done} !== {4'hB, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL hold_%0d: got res=%h c=%b v=%b rdy=%b done=%b expected b 0 0 1 0",
                     k, result, carry_out, overflow, ready, done);
         end
      end
   endtask

   task automatic test_sweep;
      int lat;
      logic [5:0] exp;
      for (int s = 0; s < 2; s++) begin
         for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
               do_op(4'(ia), 4'(ib), 1'(s), lat);
               exp = ref_op(4'(ia), 4'(ib), 1'(s));
               vectors++;
               if (lat !== 4 || {overflow, carry_out, result} !== exp) begin
                  miscompares++;
                  $display("FAIL sweep a=%0d b=%0d sub=%0d: got lat=%0d {v,c,res}=%b expected 4 %b",
                           ia, ib, s, lat, {overflow, carry_out, result}, exp);
               end
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      test_reset();
      test_add_overflow();
      test_sub();
      test_wrap();
      test_ignore_start();
      test_toggle_inputs();
      test_back_to_back();
      test_reset_mid();
      test_hold();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
